// File: rtl/mips_cpu.sv
// Single-cycle KGP-RISC (MIPS subset) CPU: fetch, decode, execute and
// write back one instruction per clock. Only the store-data bus is exposed.

// Instruction memory: 256 words, combinational read. The write port exists
// so the array is driven from inside the design; the datapath ties it off
// and programs are preloaded hierarchically.
module mips_imem (
    input  logic        clk,
    input  logic        we,
    input  logic [7:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [7:0]  addr,
    output logic [31:0] rdata
);
    logic [31:0] imem [0:255];

    // Optional program-load write port.
    always_ff @(posedge clk) begin
        if (we) imem[waddr] <= wdata;
    end

    assign rdata = imem[addr];
endmodule

// 32x32 register file: two combinational read ports and one synchronous
// write port. $0 always reads 0 and ignores writes. There is no write-to-read
// bypass, so a same-cycle read returns the old value.
module mips_regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);
    logic [31:0] regfile [0:31];

    // Reset clears every register; otherwise commit one write per cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) regfile[i] <= '0;
        end else if (we && (wa != 5'd0)) begin
            regfile[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == 5'd0) ? '0 : regfile[ra1];
    assign rd2 = (ra2 == 5'd0) ? '0 : regfile[ra2];
endmodule

// Data memory: 256 words, word-addressed, combinational read.
// Contents are not touched by reset.
module mips_dmem (
    input  logic        clk,
    input  logic        we,
    input  logic [7:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);
    logic [31:0] dmem [0:255];

    // Store commits on the clock edge.
    always_ff @(posedge clk) begin
        if (we) dmem[addr] <= wdata;
    end

    assign rdata = dmem[addr];
endmodule

// Datapath plus decode. The PC is held as a 10-bit byte address, so all
// next-PC arithmetic naturally wraps modulo 1 KiB.
module mips_datapath (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] writedata
);
    logic [9:0]         pc, pc_plus4, pc_next;
    logic [31:0]        instr, rs_val, rt_val, simm, result, mem_rdata;
    logic signed [31:0] rs_s, rt_s;
    logic [4:0]         wreg;
    logic [7:0]         eff_addr;
    logic               reg_we, mem_we;

    mips_imem imem (
        .clk(clk), .we(1'b0), .waddr(8'd0), .wdata(32'd0),
        .addr(pc[9:2]), .rdata(instr)
    );

    mips_regfile rbank (
        .clk(clk), .reset(reset), .ra1(instr[25:21]), .ra2(instr[20:16]),
        .we(reg_we), .wa(wreg), .wd(result), .rd1(rs_val), .rd2(rt_val)
    );

    mips_dmem dmem (
        .clk(clk), .we(mem_we), .addr(eff_addr), .wdata(rt_val),
        .rdata(mem_rdata)
    );

    assign simm      = {{16{instr[15]}}, instr[15:0]};
    assign rs_s      = signed'(rs_val);
    assign rt_s      = signed'(rt_val);
    assign pc_plus4  = pc + 10'd4;
    // Only the low 8 bits of rs + simm select a dmem word.
    assign eff_addr  = rs_val[7:0] + instr[7:0];
    assign writedata = rt_val;

    // Decode the current instruction into write enables, result and next PC.
    always_comb begin
        reg_we  = 1'b0;
        mem_we  = 1'b0;
        wreg    = instr[15:11];
        result  = '0;
        pc_next = pc_plus4;
        case (instr[31:26])
            6'h00: begin
                reg_we = 1'b1;
                case (instr[5:0])
                    6'h20:   result = rs_val + rt_val;
                    6'h22:   result = rs_val - rt_val;
                    6'h24:   result = rs_val & rt_val;
                    6'h25:   result = rs_val | rt_val;
                    6'h2A:   result = {31'd0, rs_s < rt_s};
                    6'h00:   result = rt_val << instr[10:6];
                    6'h02:   result = rt_val >> instr[10:6];
                    default: reg_we = 1'b0;
                endcase
            end
            6'h08: begin
                reg_we = 1'b1;
                wreg   = instr[20:16];
                result = rs_val + simm;
            end
            6'h23: begin
                reg_we = 1'b1;
                wreg   = instr[20:16];
                result = mem_rdata;
            end
            6'h2B: mem_we = !reset;
            6'h04: if (rs_val == rt_val) pc_next = pc_plus4 + {instr[7:0], 2'b00};
            6'h05: if (rs_val != rt_val) pc_next = pc_plus4 + {instr[7:0], 2'b00};
            6'h02: pc_next = {instr[7:0], 2'b00};
            default: ;
        endcase
    end

    // Program counter: restart at 0 on reset, otherwise follow decode.
    always_ff @(posedge clk) begin
        if (reset) pc <= '0;
        else       pc <= pc_next;
    end
endmodule

// Top level.
module mips_cpu (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] writedata
);
    mips_datapath dpath (
        .clk(clk), .reset(reset), .writedata(writedata)
    );
endmodule

// File: tb/tb_mips_cpu.sv
// Bench for mips_cpu: directed programs plus random programs, with an ISA-level
// reference model predicting writedata every cycle and the final machine state.
module tb_mips_cpu;
    logic        clk;
    logic        reset;
    logic [31:0] writedata;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];

    // Reference machine state
    logic [31:0] mimem [256];
    logic [31:0] mdmem [256];
    logic [31:0] mregs [32];
    logic [31:0] mpc;

    mips_cpu dut (.clk(clk), .reset(reset), .writedata(writedata));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: mid-cycle, compare writedata against the oldest prediction.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) chk("writedata", writedata, exp_q.pop_front());
        end
    end

    function automatic logic [31:0] r_ins(input int funct, input int rs, input int rt,
                                          input int rd, input int sh);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(funct)};
    endfunction

    function automatic logic [31:0] i_ins(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    task automatic model_reset();
        mpc = 0;
        for (int r = 0; r < 32; r++) mregs[r] = 0;
    endtask

    // Execute one instruction at the ISA level.
    task automatic model_step();
        logic [31:0] ins, a, b, sx, npc, w;
        int op, funct, rs, rt, rd, sh;
        bit wr;
        ins   = mimem[mpc[9:2]];
        op    = int'(ins[31:26]);
        rs    = int'(ins[25:21]);
        rt    = int'(ins[20:16]);
        rd    = int'(ins[15:11]);
        sh    = int'(ins[10:6]);
        funct = int'(ins[5:0]);
        a     = mregs[rs];
        b     = mregs[rt];
        sx    = {{16{ins[15]}}, ins[15:0]};
        npc   = mpc + 4;
        wr    = 0;
        w     = 0;
        case (op)
            'h00: begin
                wr = 1;
                case (funct)
                    'h20: w = a + b;
                    'h22: w = a - b;
                    'h24: w = a & b;
                    'h25: w = a | b;
                    'h2A: w = ($signed(a) < $signed(b)) ? 1 : 0;
                    'h00: w = b << sh;
                    'h02: w = b >> sh;
                    default: wr = 0;
                endcase
            end
            'h08: begin wr = 1; rd = rt; w = a + sx; end
            'h23: begin wr = 1; rd = rt; w = mdmem[(a + sx) % 256]; end
            'h2B: mdmem[(a + sx) % 256] = b;
            'h04: if (a == b) npc = mpc + 4 + (sx << 2);
            'h05: if (a != b) npc = mpc + 4 + (sx << 2);
            'h02: npc = {npc[31:28], ins[25:0], 2'b00};
            default: ;
        endcase
        if (wr && rd != 0) mregs[rd] = w;
        mpc = npc % 1024;
    endtask

    // Hold reset across two edges with the current memories in place.
    task automatic hard_reset();
        reset = 1'b1;
        @(posedge clk); #2;
        model_reset();
        exp_q.push_back(32'd0);
        @(posedge clk); #2;
        reset = 1'b0;
    endtask

    // Copy the model's memories into the DUT, then reset.
    task automatic start_prog();
        reset = 1'b1;
        for (int i = 0; i < 256; i++) begin
            dut.dpath.imem.imem[i] <= mimem[i];
            dut.dpath.dmem.dmem[i] <= mdmem[i];
        end
        hard_reset();
    endtask

    task automatic run(input int n);
        logic [31:0] ins;
        repeat (n) begin
            ins = mimem[mpc[9:2]];
            exp_q.push_back(mregs[ins[20:16]]);
            model_step();
            @(posedge clk); #2;
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) begin
            mimem[i] = 0;
            mdmem[i] = 0;
        end
    endtask

    task automatic compare_state(input string tag);
        for (int r = 0; r < 32; r++) chk({tag, "_reg"}, dut.dpath.rbank.regfile[r], mregs[r]);
        for (int a = 0; a < 256; a++) chk({tag, "_dmem"}, dut.dpath.dmem.dmem[a], mdmem[a]);
        chk({tag, "_pc"}, {22'd0, dut.dpath.pc}, mpc);
    endtask

    function automatic logic [31:0] rand_ins();
        int k, f;
        k = $urandom_range(0, 11);
        case (k)
            0, 1, 2, 3: begin
                case ($urandom_range(0, 7))
                    0: f = 'h20;  1: f = 'h22;  2: f = 'h24;  3: f = 'h25;
                    4: f = 'h2A;  5: f = 'h00;  6: f = 'h02;
                    default: f = int'($urandom_range(0, 63));
                endcase
                return r_ins(f, $urandom_range(0, 7), $urandom_range(0, 7),
                             $urandom_range(0, 7), $urandom_range(0, 31));
            end
            4, 5: return i_ins('h08, $urandom_range(0, 7), $urandom_range(0, 7), int'($urandom));
            6:    return i_ins('h23, $urandom_range(0, 7), $urandom_range(0, 7), int'($urandom));
            7:    return i_ins('h2B, $urandom_range(0, 7), $urandom_range(0, 7), int'($urandom));
            8:    return i_ins('h04, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 8) - 4);
            9:    return i_ins('h05, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 8) - 4);
            10:   return {6'h02, 26'($urandom)};
            default: return {($urandom_range(0, 1) != 0) ? 6'h3F : 6'h0F, 26'($urandom)};
        endcase
    endfunction

    initial begin
        int sorted[10];
        int unsorted[10];
        unsorted = '{20, 50, 10, 30, 70, 40, 60, 80, 100, 90};
        reset = 1'b1;

        // Reset state with random preloaded data that must survive reset.
        clear_mem();
        for (int i = 0; i < 256; i++) mdmem[i] = $urandom;
        start_prog();
        compare_state("reset");

        // ALU and store program.
        clear_mem();
        mimem[0] = i_ins('h08, 0, 1, 5);
        mimem[1] = i_ins('h08, 0, 2, 7);
        mimem[2] = r_ins('h20, 1, 2, 3, 0);
        mimem[3] = r_ins('h22, 2, 1, 4, 0);
        mimem[4] = i_ins('h2B, 0, 3, 7);
        mimem[5] = i_ins('h2B, 0, 4, 5);
        start_prog();
        run(4);
        chk("alu_wd_first_sw", writedata, 32'd12);
        run(4);
        chk("alu_r1", dut.dpath.rbank.regfile[1], 32'd5);
        chk("alu_r2", dut.dpath.rbank.regfile[2], 32'd7);
        chk("alu_r3", dut.dpath.rbank.regfile[3], 32'd12);
        chk("alu_r4", dut.dpath.rbank.regfile[4], 32'd2);
        chk("alu_dmem7", dut.dpath.dmem.dmem[7], 32'd12);
        chk("alu_dmem5", dut.dpath.dmem.dmem[5], 32'd2);
        compare_state("alu");

        // GCD(48, 18) with slt/beq/bne/sub/j.
        clear_mem();
        mimem[0]  = i_ins('h08, 0, 1, 48);
        mimem[1]  = i_ins('h08, 0, 2, 18);
        mimem[2]  = i_ins('h2B, 0, 1, 0);
        mimem[3]  = i_ins('h2B, 0, 2, 1);
        mimem[4]  = i_ins('h04, 1, 2, 6);
        mimem[5]  = r_ins('h2A, 1, 2, 3, 0);
        mimem[6]  = i_ins('h05, 3, 0, 2);
        mimem[7]  = r_ins('h22, 1, 2, 1, 0);
        mimem[8]  = {6'h02, 26'd4};
        mimem[9]  = r_ins('h22, 2, 1, 2, 0);
        mimem[10] = {6'h02, 26'd4};
        mimem[11] = i_ins('h2B, 0, 1, 2);
        mimem[12] = i_ins('h04, 0, 0, -1);
        start_prog();
        run(80);
        chk("gcd_r1", dut.dpath.rbank.regfile[1], 32'd6);
        chk("gcd_dmem0", dut.dpath.dmem.dmem[0], 32'd48);
        chk("gcd_dmem1", dut.dpath.dmem.dmem[1], 32'd18);
        chk("gcd_dmem2", dut.dpath.dmem.dmem[2], 32'd6);
        chk("gcd_halt_pc", {22'd0, dut.dpath.pc}, 32'd48);

        // Bubble sort of dmem[100..109].
        clear_mem();
        for (int i = 0; i < 10; i++) mdmem[100 + i] = unsorted[i];
        mimem[0]  = i_ins('h08, 0, 5, 9);
        mimem[1]  = i_ins('h08, 0, 6, 100);
        mimem[2]  = i_ins('h08, 0, 7, 9);
        mimem[3]  = i_ins('h23, 6, 8, 0);
        mimem[4]  = i_ins('h23, 6, 9, 1);
        mimem[5]  = r_ins('h2A, 9, 8, 10, 0);
        mimem[6]  = i_ins('h04, 10, 0, 2);
        mimem[7]  = i_ins('h2B, 6, 9, 0);
        mimem[8]  = i_ins('h2B, 6, 8, 1);
        mimem[9]  = i_ins('h08, 6, 6, 1);
        mimem[10] = i_ins('h08, 7, 7, -1);
        mimem[11] = i_ins('h05, 7, 0, -9);
        mimem[12] = i_ins('h08, 5, 5, -1);
        mimem[13] = i_ins('h05, 5, 0, -13);
        mimem[14] = i_ins('h04, 0, 0, -1);
        start_prog();
        run(800);
        for (int i = 0; i < 10; i++) sorted[i] = 10 * (i + 1);
        for (int i = 0; i < 10; i++) chk("sort", dut.dpath.dmem.dmem[100 + i], 32'(sorted[i]));
        compare_state("sort");

        // Corner cases.
        clear_mem();
        mimem[0] = i_ins('h08, 0, 0, 5);
        mimem[1] = i_ins('h08, 0, 1, -1);
        mimem[2] = i_ins('h08, 0, 2, 1);
        mimem[3] = r_ins('h2A, 1, 2, 3, 0);
        mimem[4] = r_ins('h02, 0, 1, 4, 1);
        mimem[5] = r_ins('h20, 4, 2, 5, 0);
        mimem[6] = {6'h3F, 5'd1, 5'd6, 16'h1234};
        mimem[7] = i_ins('h2B, 0, 5, 3);
        mimem[8] = i_ins('h04, 0, 0, -1);
        start_prog();
        run(20);
        chk("r0_stays_zero", dut.dpath.rbank.regfile[0], 32'd0);
        chk("slt_neg1_lt_1", dut.dpath.rbank.regfile[3], 32'd1);
        chk("srl_max_pos", dut.dpath.rbank.regfile[4], 32'h7FFF_FFFF);
        chk("add_wrap", dut.dpath.rbank.regfile[5], 32'h8000_0000);
        chk("undef_op_nowrite", dut.dpath.rbank.regfile[6], 32'd0);
        chk("store_after_undef", dut.dpath.dmem.dmem[3], 32'h8000_0000);
        chk("beq_self_loop_pc", {22'd0, dut.dpath.pc}, 32'd32);

        // Random programs, one with a mid-program reset.
        for (int s = 0; s < 4; s++) begin
            for (int i = 0; i < 256; i++) begin
                mimem[i] = rand_ins();
                mdmem[i] = $urandom;
            end
            start_prog();
            run(300);
            if (s == 3) begin
                hard_reset();
                run(200);
            end
            compare_state("random");
        end

        @(negedge clk); #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
